// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream loader that assembles words and writes them into instruction memory
// Optional trailer checksum check is enabled by defining LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             cpu_hold
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_CHECK} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;
`endif

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic             len_bad;
  logic             word_last;

  assign len_bad   = (len_words == '0) || (len_words > CNT_W'(MAX_WORDS));
  assign word_last = ((word_idx + ONE) == len_q);
  assign mem_addr  = {{(30-CNT_W){1'b0}}, word_idx, 2'b00};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       sum_ok;
  assign sum_ok = ((sum_q + byte_data) == 8'h00);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE, S_DONE: begin
        done     = (state == S_DONE);
        cpu_hold = (state != S_DONE);
        if (start) state_nxt = len_bad ? S_IDLE : S_LOAD;
      end
      S_LOAD: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid && byte_idx == 2'd3) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        mem_we = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        state_nxt = word_last ? S_CHECK : S_LOAD;
`else
        state_nxt = word_last ? S_DONE : S_LOAD;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        busy       = 1'b1;
        byte_ready = 1'b1;
        if (byte_valid) state_nxt = sum_ok ? S_DONE : S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: length, word/byte indices, word assembly and the sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= '0;
      word_idx  <= '0;
      byte_idx  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (len_bad) begin
              error <= 1'b1;
            end else begin
              error    <= 1'b0;
              len_q    <= len_words;
              word_idx <= '0;
              byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
              sum_q    <= '0;
`endif
            end
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            mem_wdata[{byte_idx, 3'b000} +: 8] <= byte_data;
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_q + byte_data;
`endif
          end
        end
        S_WRITE: word_idx <= word_idx + ONE;
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: if (byte_valid && !sum_ok) error <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader against a word-list reference model
module tb_imem_loader;
  localparam int MAX_WORDS = 256;
  localparam int CNT_W     = 9;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len_words = '0;
  logic             byte_valid = 1'b0;
  logic [7:0]       byte_data = '0;
  logic             byte_ready, mem_we, busy, done, error, cpu_hold;
  logic [31:0]      mem_addr, mem_wdata;

  imem_loader #(.MAX_WORDS(MAX_WORDS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int to_cnt = 0;
  int cyc = 0;
  int lat = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] exp_words[$];

`ifdef LOADER_CHECKSUM_EN
  localparam int CS_EXTRA = 1;
`else
  localparam int CS_EXTRA = 0;
`endif

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input int gap, input bit noise);
    int n;
    repeat (gap) begin @(negedge clk); byte_valid = 1'b0; end
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    if (noise) begin start = 1'b1; len_words = CNT_W'(1); end
    n = 0;
    while (!byte_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) to_cnt++;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  // Drives a full load and builds the expected word list from the raw bytes.
  task automatic do_load(input int n, input int gap_max, input bit noise, input bit bad_trailer,
                         input bit use_fixed, input logic [31:0] fixed_word);
    logic [7:0]  sum;
    logic [7:0]  b;
    logic [31:0] word;
    int c0, w;
    sum = 8'h00;
    exp_words.delete();
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start = 1'b1;
    len_words = CNT_W'(n);
    c0 = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < n; i++) begin
      word = use_fixed ? fixed_word : 32'($urandom);
      for (int k = 0; k < 4; k++) begin
        b = word[8*k +: 8];
        sum = sum + b;
        send_byte(b, (gap_max > 0) ? $urandom_range(0, gap_max) : 0,
                  noise && ($urandom_range(0, 3) == 0));
      end
      exp_words.push_back(word);
    end
`ifdef LOADER_CHECKSUM_EN
    b = 8'h00 - sum;
    if (bad_trailer) b = b ^ 8'h5a;
    send_byte(b, 0, 1'b0);
`else
    if (bad_trailer) to_cnt = to_cnt + 0;
`endif
    w = 0;
    while (!(done || error) && w < 20) begin @(negedge clk); w++; end
    if (w >= 20) to_cnt++;
    lat = cyc - c0;
  endtask

  task automatic test_reset;
    total++; if (byte_ready !== 1'b0) begin bad++; $display("FAIL rst0_ready got=%b exp=0", byte_ready); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst0_hold got=%b exp=1", cpu_hold); end
    total++; if ({mem_we, busy, done, error} !== 4'b0) begin bad++; $display("FAIL rst0_flags got=%b exp=0000", {mem_we, busy, done, error}); end
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    start = 1'b1; len_words = CNT_W'(2);
    @(posedge clk);
    #1 start = 1'b0;
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h3C, 0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL pre_rst_busy got=%b exp=1", busy); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if ({byte_ready, mem_we, busy, done, error} !== 5'b0) begin bad++; $display("FAIL async_rst_flags got=%b exp=00000", {byte_ready, mem_we, busy, done, error}); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL async_rst_wdata got=%h exp=0", mem_wdata); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL async_rst_addr got=%h exp=0", mem_addr); end
    total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL async_rst_hold got=%b exp=1", cpu_hold); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_single_word;
    do_load(1, 0, 1'b0, 1'b0, 1'b1, 32'h00000013);
    total++; if (wr_addr.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() > 0) begin
      total++; if (wr_addr[0] !== 32'h0) begin bad++; $display("FAIL single_addr got=%h exp=0", wr_addr[0]); end
      total++; if (wr_data[0] !== 32'h00000013) begin bad++; $display("FAIL single_data got=%h exp=00000013", wr_data[0]); end
    end
    total++; if ({done, cpu_hold, busy, error, byte_ready} !== 5'b10000) begin bad++; $display("FAIL single_status got=%b exp=10000", {done, cpu_hold, busy, error, byte_ready}); end
    total++; if (lat !== 5 * 1 + 1 + CS_EXTRA) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", lat, 5 + 1 + CS_EXTRA); end
    total++; if (to_cnt !== 0) begin bad++; $display("FAIL single_timeout got=%0d exp=0", to_cnt); end
  endtask

  task automatic test_backpressure;
    int n;
    for (int it = 0; it < 4; it++) begin
      n = (it == 0) ? 2 : $urandom_range(1, 5);
      do_load(n, 3, 1'b1, 1'b0, 1'b0, 32'h0);
      total++; if (wr_addr.size() !== n) begin bad++; $display("FAIL bp_count it=%0d got=%0d exp=%0d", it, wr_addr.size(), n); end
      for (int i = 0; i < n && i < wr_addr.size(); i++) begin
        total++; if (wr_addr[i] !== 32'(i * 4)) begin bad++; $display("FAIL bp_addr i=%0d got=%h exp=%h", i, wr_addr[i], i * 4); end
        total++; if (wr_data[i] !== exp_words[i]) begin bad++; $display("FAIL bp_data i=%0d got=%h exp=%h", i, wr_data[i], exp_words[i]); end
      end
      total++; if ({done, error, cpu_hold} !== 3'b100) begin bad++; $display("FAIL bp_status it=%0d got=%b exp=100", it, {done, error, cpu_hold}); end
    end
    total++; if (to_cnt !== 0) begin bad++; $display("FAIL bp_timeout got=%0d exp=0", to_cnt); end
  endtask

  task automatic test_max_len;
    int errs;
    errs = 0;
    do_load(MAX_WORDS, 0, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if (wr_addr.size() !== MAX_WORDS) begin bad++; $display("FAIL max_count got=%0d exp=%0d", wr_addr.size(), MAX_WORDS); end
    for (int i = 0; i < MAX_WORDS && i < wr_addr.size(); i++)
      if (wr_addr[i] !== 32'(i * 4) || wr_data[i] !== exp_words[i]) errs++;
    total++; if (errs !== 0) begin bad++; $display("FAIL max_words got=%0d wrong exp=0", errs); end
    total++; if (lat !== 5 * MAX_WORDS + 1 + CS_EXTRA) begin bad++; $display("FAIL max_latency got=%0d exp=%0d", lat, 5 * MAX_WORDS + 1 + CS_EXTRA); end
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL max_status got=%b exp=10", {done, error}); end
  endtask

  task automatic test_bad_length;
    int lens[2];
    lens[0] = 0;
    lens[1] = MAX_WORDS + 1;
    for (int j = 0; j < 2; j++) begin
      wr_addr.delete();
      wr_data.delete();
      @(negedge clk);
      start = 1'b1; len_words = CNT_W'(lens[j]);
      @(posedge clk);
      #1 start = 1'b0;
      byte_valid = 1'b1; byte_data = 8'h77;
      repeat (3) @(negedge clk);
      total++; if (error !== 1'b1) begin bad++; $display("FAIL badlen_error len=%0d got=%b exp=1", lens[j], error); end
      total++; if ({done, busy, byte_ready, cpu_hold} !== 4'b0001) begin bad++; $display("FAIL badlen_status len=%0d got=%b exp=0001", lens[j], {done, busy, byte_ready, cpu_hold}); end
      total++; if (wr_addr.size() !== 0) begin bad++; $display("FAIL badlen_we len=%0d got=%0d exp=0", lens[j], wr_addr.size()); end
      byte_valid = 1'b0;
    end
    do_load(1, 1, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if ({done, error} !== 2'b10) begin bad++; $display("FAIL badlen_recover got=%b exp=10", {done, error}); end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    do_load(1, 0, 1'b0, 1'b1, 1'b0, 32'h0);
    total++; if ({error, done, cpu_hold, busy} !== 4'b1010) begin bad++; $display("FAIL cs_bad_status got=%b exp=1010", {error, done, cpu_hold, busy}); end
    do_load(2, 2, 1'b0, 1'b0, 1'b0, 32'h0);
    total++; if ({error, done, cpu_hold} !== 3'b010) begin bad++; $display("FAIL cs_good_status got=%b exp=010", {error, done, cpu_hold}); end
    total++; if (to_cnt !== 0) begin bad++; $display("FAIL cs_timeout got=%0d exp=0", to_cnt); end
  endtask
`endif

  task automatic test_reset_during_load;
    logic [31:0] w0;
    logic [7:0]  b;
    w0 = 32'($urandom);
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk);
    start = 1'b1; len_words = CNT_W'(3);
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      b = (k < 4) ? w0[8*k +: 8] : 8'($urandom);
      send_byte(b, 0, 1'b0);
    end
    @(negedge clk);
    rst = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h11;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (wr_addr.size() !== 1) begin bad++; $display("FAIL rstload_count got=%0d exp=1", wr_addr.size()); end
    if (wr_addr.size() > 0) begin
      total++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== w0) begin bad++; $display("FAIL rstload_word got=%h@%h exp=%h@0", wr_data[0], wr_addr[0], w0); end
    end
    total++; if ({busy, byte_ready, done, mem_we, cpu_hold} !== 5'b00001) begin bad++; $display("FAIL rstload_idle got=%b exp=00001", {busy, byte_ready, done, mem_we, cpu_hold}); end
    byte_valid = 1'b0;
    total++; if (to_cnt !== 0) begin bad++; $display("FAIL rstload_timeout got=%0d exp=0", to_cnt); end
  endtask

  initial begin
    #2;
    test_reset();
    test_single_word();
    test_backpressure();
    test_max_len();
    test_bad_length();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_during_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
